// File: rtl/sdram_bridge_pkg.sv
// Shared constants and state encodings for the serial SDRAM command bridge.
// The command-word layout {write flag, address, data} is also used by the arbiter.
package sdram_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] ERR_BYTE = 8'h3F;  // '?', reported for an unknown opcode

  // Width of the data field at the bottom of a command word.
  localparam int CMD_DATA_W = 8;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR_HI,
    P_ADDR_LO,
    P_DATA,
    P_PUSH
  } parser_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT,
    T_CAPTURE,
    T_SEND
  } tx_state_t;

endpackage

// File: rtl/serial_sdram_cmd_bridge_tx_response_sequencer.sv
// TX side of the bridge: pops read results from the response FIFO and hands
// them, or a single pending error byte, to the UART transmitter.
//
// Handshake (tx_valid/tx_ready): tx_valid rises with tx_byte already stable,
// stays high and tx_byte is frozen until a cycle where tx_valid and tx_ready
// are both high; that cycle transfers the byte and the FSM leaves T_SEND on
// the following edge.
module tx_response_sequencer
  import sdram_bridge_pkg::*;
(
  input  logic       clk8M,
  input  logic       reset,
  input  logic       err_set,
  input  logic       resp_empty,
  output logic       resp_pop,
  input  logic [7:0] resp_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte
);

  tx_state_t state;
  tx_state_t state_next;
  logic      err_pending;
  logic      load_err;
  logic      load_resp;

  // State register.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      state <= T_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and pop strobe; response data wins over a pending error byte.
  always_comb begin
    state_next = state;
    resp_pop   = 1'b0;
    load_err   = 1'b0;
    load_resp  = 1'b0;
    case (state)
      T_IDLE: begin
        if (!resp_empty) begin
          resp_pop   = 1'b1;
          state_next = T_WAIT;
        end else if (err_pending) begin
          load_err   = 1'b1;
          state_next = T_SEND;
        end
      end
      T_WAIT:    state_next = T_CAPTURE;
      T_CAPTURE: begin
        load_resp  = 1'b1;
        state_next = T_SEND;
      end
      T_SEND: begin
        if (tx_ready) state_next = T_IDLE;
      end
      default:   state_next = T_IDLE;
    endcase
  end

  assign tx_valid = (state == T_SEND);

  // Output byte register; only written outside T_SEND so it never moves while valid.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      tx_byte <= 8'h00;
    end else if (load_resp) begin
      tx_byte <= resp_data;
    end else if (load_err) begin
      tx_byte <= ERR_BYTE;
    end
  end

  // One-bit error latch: repeated errors collapse; a new error in the load cycle is kept.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      err_pending <= 1'b0;
    end else if (err_set) begin
      err_pending <= 1'b1;
    end else if (load_err) begin
      err_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_sdram_cmd_bridge.sv
// Serial-side endpoint of the SDRAM tester command path: parses UART bytes into
// packed command words for the command FIFO and streams read results back out.
module serial_sdram_cmd_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk8M,
  input  logic                  reset,
  input  logic                  rxValid,
  input  logic [7:0]            rxByte,
  input  logic                  cmdFifoFull,
  output logic                  cmdFifoWriteStrobe,
  output logic [ADDR_WIDTH+8:0] cmdFifoData,
  input  logic                  respFifoEmpty,
  output logic                  respFifoReadStrobe,
  input  logic [7:0]            respFifoData,
  input  logic                  txReady,
  output logic                  txValid,
  output logic [7:0]            txByte,
  output logic                  bridgeError
);

  parser_state_t         p_state;
  parser_state_t         p_next;
  logic                  is_write;
  logic [7:0]            addr_hi;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           addr_pair;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH+8:0] cmd_next;
  logic                  load_cmd;
  logic                  unknown_op;
  logic                  overrun;
  logic                  is_opcode;

  // Address upper bits beyond ADDR_WIDTH are simply discarded.
  assign addr_pair = {addr_hi, rxByte};
  assign addr_in   = addr_pair[ADDR_WIDTH-1:0];
  assign is_opcode = (rxByte == OP_WRITE) || (rxByte == OP_READ);

  // Parser state register.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      p_state <= P_IDLE;
    end else begin
      p_state <= p_next;
    end
  end

  // Parser next state, push strobe and error events.
  always_comb begin
    p_next             = p_state;
    load_cmd           = 1'b0;
    unknown_op         = 1'b0;
    overrun            = 1'b0;
    cmdFifoWriteStrobe = 1'b0;
    case (p_state)
      P_IDLE: begin
        if (rxValid) begin
          if (is_opcode) p_next = P_ADDR_HI;
          else           unknown_op = 1'b1;
        end
      end
      P_ADDR_HI: begin
        if (rxValid) p_next = P_ADDR_LO;
      end
      P_ADDR_LO: begin
        if (rxValid) begin
          if (is_write) begin
            p_next = P_DATA;
          end else begin
            load_cmd = 1'b1;
            p_next   = P_PUSH;
          end
        end
      end
      P_DATA: begin
        if (rxValid) begin
          load_cmd = 1'b1;
          p_next   = P_PUSH;
        end
      end
      P_PUSH: begin
        // No backpressure on rx: a byte arriving here is lost and flagged.
        overrun = rxValid;
        if (!cmdFifoFull) begin
          cmdFifoWriteStrobe = 1'b1;
          p_next             = P_IDLE;
        end
      end
      default: p_next = P_IDLE;
    endcase
  end

  // Command word as it will be pushed; reads carry a zero data field.
  always_comb begin
    cmd_next = {1'b0, addr_in, 8'h00};
    if (p_state == P_DATA) cmd_next = {1'b1, addr_q, rxByte};
  end

  // Field capture and the registered command word, held until the next push.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      is_write    <= 1'b0;
      addr_hi     <= 8'h00;
      addr_q      <= '0;
      cmdFifoData <= '0;
    end else begin
      if (p_state == P_IDLE && rxValid && is_opcode) is_write <= (rxByte == OP_WRITE);
      if (p_state == P_ADDR_HI && rxValid)           addr_hi  <= rxByte;
      if (p_state == P_ADDR_LO && rxValid)           addr_q   <= addr_in;
      if (load_cmd)                                  cmdFifoData <= cmd_next;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      bridgeError <= 1'b0;
    end else if (unknown_op || overrun) begin
      bridgeError <= 1'b1;
    end
  end

  tx_response_sequencer u_tx (
    .clk8M      (clk8M),
    .reset      (reset),
    .err_set    (unknown_op),
    .resp_empty (respFifoEmpty),
    .resp_pop   (respFifoReadStrobe),
    .resp_data  (respFifoData),
    .tx_ready   (txReady),
    .tx_valid   (txValid),
    .tx_byte    (txByte)
  );

endmodule

// File: tb/tb_serial_sdram_cmd_bridge.sv
// Directed bench for serial_sdram_cmd_bridge with a response-FIFO model,
// command and TX scoreboards, and a single check task.
module tb_serial_sdram_cmd_bridge;

  logic        clk8M = 1'b0;
  logic        reset = 1'b0;
  logic        rxValid = 1'b0;
  logic [7:0]  rxByte = 8'h00;
  logic        cmdFifoFull = 1'b0;
  logic        cmdFifoWriteStrobe;
  logic [24:0] cmdFifoData;
  logic        respFifoEmpty = 1'b1;
  logic        respFifoReadStrobe;
  logic [7:0]  respFifoData = 8'h00;
  logic        txReady = 1'b1;
  logic        txValid;
  logic [7:0]  txByte;
  logic        bridgeError;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int push_count = 0;
  int last_push_cyc = -1;
  int last_rstrobe_cyc = -1;
  int cmd_extra = 0;
  int tx_extra = 0;
  int hold_viol = 0;

  logic [24:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  resp_q[$];

  serial_sdram_cmd_bridge #(.ADDR_WIDTH(16)) dut (
    .clk8M              (clk8M),
    .reset              (reset),
    .rxValid            (rxValid),
    .rxByte             (rxByte),
    .cmdFifoFull        (cmdFifoFull),
    .cmdFifoWriteStrobe (cmdFifoWriteStrobe),
    .cmdFifoData        (cmdFifoData),
    .respFifoEmpty      (respFifoEmpty),
    .respFifoReadStrobe (respFifoReadStrobe),
    .respFifoData       (respFifoData),
    .txReady            (txReady),
    .txValid            (txValid),
    .txByte             (txByte),
    .bridgeError        (bridgeError)
  );

  // clock / cycle counter
  always #5 clk8M = ~clk8M;
  always @(posedge clk8M) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // response FIFO model: data valid in the second cycle after the pop strobe
  logic [7:0] pend_data = 8'h00;
  int         dcnt = 0;
  always @(posedge clk8M) begin
    if (dcnt == 1) begin
      respFifoData <= pend_data;
      dcnt = 2;
    end else if (dcnt == 2) begin
      respFifoData <= 8'h00;
      dcnt = 0;
    end
    if (respFifoReadStrobe && resp_q.size() > 0) begin
      pend_data = resp_q.pop_front();
      dcnt = 1;
    end
    respFifoEmpty <= (resp_q.size() == 0);
  end

  // command scoreboard and pop-strobe timestamp
  always @(negedge clk8M) begin
    if (respFifoReadStrobe) last_rstrobe_cyc = cyc;
    if (cmdFifoWriteStrobe) begin
      push_count++;
      last_push_cyc = cyc;
      if (exp_cmd_q.size() > 0) check("cmd_word", {7'd0, cmdFifoData}, {7'd0, exp_cmd_q.pop_front()});
      else cmd_extra++;
    end
  end

  // TX scoreboard and hold-stability monitor
  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  always @(negedge clk8M) begin
    if (txValid) begin
      if (prev_hold && txByte != prev_byte) hold_viol++;
      if (txReady) begin
        if (exp_tx_q.size() > 0) check("tx_byte", {24'd0, txByte}, {24'd0, exp_tx_q.pop_front()});
        else tx_extra++;
      end
      prev_hold = !txReady;
      prev_byte = txByte;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // driver tasks (all leave time at 1 unit after a rising edge)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk8M);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxByte = b;
    rxValid = 1'b1;
    last_rx_cyc = cyc;
    step(1);
    rxValid = 1'b0;
  endtask

  task automatic expect_push(input string tag, input int pc0);
    step(3);
    check({tag, "_cnt"}, push_count - pc0, 1);
    check({tag, "_cyc"}, last_push_cyc, last_rx_cyc + 1);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk8M);
    #1;
    reset = 1'b1;
    rxValid = 1'b0;
    #1;
    check({tag, "_wstrobe"}, cmdFifoWriteStrobe, 0);
    check({tag, "_cmddata"}, cmdFifoData, 0);
    check({tag, "_rstrobe"}, respFifoReadStrobe, 0);
    check({tag, "_txvalid"}, txValid, 0);
    check({tag, "_txbyte"}, txByte, 0);
    check({tag, "_err"}, bridgeError, 0);
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  int  pc0;
  int  f_cyc;
  logic found;

  initial begin
    do_reset("rst0");

    // write path
    pc0 = push_count;
    exp_cmd_q.push_back(25'h1_1234_A5);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    expect_push("wr", pc0);
    check("wr_err", bridgeError, 0);

    // read path with delayed txReady
    pc0 = push_count;
    exp_cmd_q.push_back(25'h0_0010_00);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    expect_push("rd", pc0);
    txReady = 1'b0;
    resp_q.push_back(8'h5C);
    exp_tx_q.push_back(8'h5C);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (txValid) found = 1'b1;
    end
    check("rd_tx_seen", found, 1);
    if (found) check("rd_tx_lat", cyc - last_rstrobe_cyc, 3);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("rd_hold_byte", txByte, 8'h5C);
      check("rd_hold_valid", txValid, 1);
    end
    txReady = 1'b1;
    step(3);
    check("rd_tx_drained", exp_tx_q.size(), 0);

    // FIFO full stall with an overrun byte
    check("full_err_before", bridgeError, 0);
    cmdFifoFull = 1'b1;
    pc0 = push_count;
    exp_cmd_q.push_back(25'h1_ABCD_11);
    send_byte(8'h57); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h11);
    send_byte(8'h52);
    step(3);
    check("full_no_push", push_count - pc0, 0);
    check("full_err_after", bridgeError, 1);
    cmdFifoFull = 1'b0;
    f_cyc = cyc;
    step(2);
    check("full_push_cnt", push_count - pc0, 1);
    check("full_push_cyc", last_push_cyc, f_cyc);
    pc0 = push_count;
    exp_cmd_q.push_back(25'h1_0005_66);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h05); send_byte(8'h66);
    expect_push("post_full", pc0);
    step(4);
    check("full_no_errbyte", tx_extra, 0);

    do_reset("rst1");

    // unknown opcode
    exp_tx_q.push_back(8'h3F);
    send_byte(8'h41);
    step(1);
    check("unk_err", bridgeError, 1);
    step(8);
    check("unk_tx_drained", exp_tx_q.size(), 0);
    pc0 = push_count;
    exp_cmd_q.push_back(25'h1_0001_FF);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'hFF);
    expect_push("unk_next", pc0);

    // priority: response beats pending error; two errors collapse to one 0x3F
    txReady = 1'b0;
    resp_q.push_back(8'hA1);
    exp_tx_q.push_back(8'hA1);
    exp_tx_q.push_back(8'hB2);
    exp_tx_q.push_back(8'h3F);
    step(6);
    send_byte(8'h41);
    send_byte(8'h43);
    resp_q.push_back(8'hB2);
    step(3);
    txReady = 1'b1;
    step(15);
    check("prio_drained", exp_tx_q.size(), 0);
    check("prio_err", bridgeError, 1);

    // reset mid-command
    send_byte(8'h57); send_byte(8'h12);
    do_reset("rst2");
    pc0 = push_count;
    exp_cmd_q.push_back(25'h0_0002_00);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
    expect_push("after_rst", pc0);

    // final report
    step(4);
    check("cmd_left", exp_cmd_q.size(), 0);
    check("cmd_extra", cmd_extra, 0);
    check("tx_left", exp_tx_q.size(), 0);
    check("tx_extra", tx_extra, 0);
    check("tx_hold", hold_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
